// File: rtl/aes_pkg.sv
// Shared constants and types for the AES-128 decrypt sequencer and its key store.
package aes_pkg;

   localparam int unsigned NUM_ROUNDS      = 10;
   localparam int unsigned BLOCK_BYTES     = 16;
   localparam int unsigned KEY_STORE_BYTES = 176;

   localparam int unsigned DEF_FIRST_KEY_GAP = 61;
   localparam int unsigned DEF_ROUND_PERIOD  = 81;
   localparam int unsigned DEF_DONE_LAT      = 60;

   typedef enum logic [2:0] {
      StIdle,
      StBurst0,
      StGap,
      StBurst,
      StDrain,
      StDone
   } seq_state_e;

endpackage

// File: rtl/aes_key_store.sv
// 176-byte round-key register file: one write port, one combinational read port.
module aes_key_store
   import aes_pkg::*;
(
   input  logic       clock,
   input  logic       we,
   input  logic [7:0] waddr,
   input  logic [7:0] wdata,
   input  logic [7:0] raddr,
   output logic [7:0] rdata
);

   localparam logic [7:0] LastAddr = 8'(KEY_STORE_BYTES - 1);

   logic [7:0] mem [KEY_STORE_BYTES];

   // Contents survive reset so keys need not be reloaded after an abort.
   always_ff @(posedge clock) begin
      if (we && (waddr <= LastAddr)) begin
         mem[waddr] <= wdata;
      end
   end

   always_comb begin
      rdata = 8'h00;
      if (raddr <= LastAddr) begin
         rdata = mem[raddr];
      end
   end

endmodule

// File: rtl/aes_decrypt_sequencer.sv
// Drives the byte-serial decrypt core with ciphertext and round keys (10 down to 0)
// in fixed cycle windows, then captures the core's plaintext.
module aes_decrypt_sequencer #(
   parameter int unsigned FIRST_KEY_GAP = aes_pkg::DEF_FIRST_KEY_GAP,
   parameter int unsigned ROUND_PERIOD  = aes_pkg::DEF_ROUND_PERIOD,
   parameter int unsigned DONE_LAT      = aes_pkg::DEF_DONE_LAT
) (
   input  logic         clock,
   input  logic         reset_n,
   input  logic         kw_en,
   input  logic [7:0]   kw_addr,
   input  logic [7:0]   kw_data,
   input  logic         start,
   input  logic [127:0] ct_data,
   output logic         ready,
   output logic         busy,
   output logic         done,
   output logic [127:0] pt,
   output logic [7:0]   core_in,
   output logic [7:0]   core_key,
   output logic         core_enable,
   input  logic [127:0] core_message
);

   import aes_pkg::*;

   // Countdown loads: a gap/drain of N cycles ends when the counter reaches zero.
   localparam logic [7:0] GapFirst  = 8'(FIRST_KEY_GAP - BLOCK_BYTES - 1);
   localparam logic [7:0] GapRound  = 8'(ROUND_PERIOD - BLOCK_BYTES - 1);
   localparam logic [7:0] DrainLoad = 8'(DONE_LAT - 1);
   localparam logic [3:0] LastByte  = 4'(BLOCK_BYTES - 1);
   localparam logic [3:0] LastRound = 4'(NUM_ROUNDS);

   seq_state_e   state_q, state_d;
   logic [3:0]   byte_q, byte_d;
   logic [3:0]   round_q, round_d;
   logic [7:0]   gap_q, gap_d;
   logic [127:0] ct_q, ct_d;
   logic [127:0] pt_q, pt_d;
   logic [7:0]   in_q, in_d;
   logic [7:0]   key_q, key_d;
   logic         en_q, en_d;

   logic       accept;
   logic       last_byte;
   logic       gap_zero;
   logic [3:0] rd_round;
   logic [3:0] rd_byte;
   logic [7:0] key_rdata;

   assign busy        = (state_q != StIdle);
   assign ready       = ~busy;
   assign done        = (state_q == StDone);
   assign pt          = pt_q;
   assign core_in     = in_q;
   assign core_key    = key_q;
   assign core_enable = en_q;

   assign accept    = start && ready;
   assign last_byte = (byte_q == LastByte);
   assign gap_zero  = (gap_q == 8'd0);

   aes_key_store u_key_store (
      .clock (clock),
      .we    (kw_en && !busy),
      .waddr (kw_addr),
      .wdata (kw_data),
      .raddr ({rd_round, rd_byte}),
      .rdata (key_rdata)
   );

   // Address of the key byte to be driven on the next cycle.
   always_comb begin
      rd_round = round_q;
      rd_byte  = byte_q + 4'd1;
      if (state_q == StIdle) begin
         rd_round = LastRound;
         rd_byte  = 4'd0;
      end else if (state_q == StGap) begin
         rd_round = round_q - 4'd1;
         rd_byte  = 4'd0;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
         byte_q  <= 4'd0;
         round_q <= 4'd0;
         gap_q   <= 8'd0;
         ct_q    <= '0;
         pt_q    <= '0;
         in_q    <= 8'd0;
         key_q   <= 8'd0;
         en_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         byte_q  <= byte_d;
         round_q <= round_d;
         gap_q   <= gap_d;
         ct_q    <= ct_d;
         pt_q    <= pt_d;
         in_q    <= in_d;
         key_q   <= key_d;
         en_q    <= en_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (accept) state_d = StBurst0;
         StBurst0: if (last_byte) state_d = StGap;
         StGap:    if (gap_zero) state_d = StBurst;
         StBurst: begin
            if (last_byte) state_d = (round_q == 4'd0) ? StDrain : StGap;
         end
         StDrain:  if (gap_zero) state_d = StDone;
         StDone:   state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   always_comb begin
      byte_d  = byte_q;
      round_d = round_q;
      gap_d   = gap_q;
      ct_d    = ct_q;
      pt_d    = pt_q;
      in_d    = in_q;
      key_d   = key_q;
      en_d    = en_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               round_d = rd_round;
               byte_d  = rd_byte;
               in_d    = ct_data[127:120];
               ct_d    = {ct_data[119:0], 8'h00};
               key_d   = key_rdata;
               en_d    = 1'b1;
            end
         end
         StBurst0: begin
            if (!last_byte) begin
               byte_d = rd_byte;
               in_d   = ct_q[127:120];
               ct_d   = {ct_q[119:0], 8'h00};
               key_d  = key_rdata;
            end else begin
               byte_d = 4'd0;
               gap_d  = GapFirst;
            end
         end
         StGap: begin
            if (gap_zero) begin
               round_d = rd_round;
               byte_d  = rd_byte;
               key_d   = key_rdata;
            end else begin
               gap_d = gap_q - 8'd1;
            end
         end
         StBurst: begin
            if (!last_byte) begin
               byte_d = rd_byte;
               key_d  = key_rdata;
            end else begin
               byte_d = 4'd0;
               gap_d  = (round_q == 4'd0) ? DrainLoad : GapRound;
            end
         end
         StDrain: begin
            if (gap_zero) begin
               en_d = 1'b0;
               pt_d = core_message;
            end else begin
               gap_d = gap_q - 8'd1;
            end
         end
         StDone: ;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_aes_decrypt_sequencer.sv
// Directed bench: FIPS-197 key schedule and stream windows, busy protection,
// mid-sequence reset and back-to-back start.
module tb_aes_decrypt_sequencer;

   logic         clock = 1'b0;
   logic         reset_n = 1'b0;
   logic         kw_en = 1'b0;
   logic [7:0]   kw_addr = 8'd0;
   logic [7:0]   kw_data = 8'd0;
   logic         start = 1'b0;
   logic [127:0] ct_data = '0;
   logic         ready, busy, done, core_enable;
   logic [127:0] pt;
   logic [7:0]   core_in, core_key;
   logic [127:0] core_message = '0;

   aes_decrypt_sequencer dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .kw_en        (kw_en),
      .kw_addr      (kw_addr),
      .kw_data      (kw_data),
      .start        (start),
      .ct_data      (ct_data),
      .ready        (ready),
      .busy         (busy),
      .done         (done),
      .pt           (pt),
      .core_in      (core_in),
      .core_key     (core_key),
      .core_enable  (core_enable),
      .core_message (core_message)
   );

   always #5 clock = ~clock;

   typedef struct {
      int unsigned off;
      logic [7:0]  exp_in;
      logic [7:0]  exp_key;
      logic        exp_en;
      logic        exp_done;
      logic        exp_ready;
   } vec_t;

   vec_t         vec [40];
   int           nv = 0;
   int           n_checks = 0;
   int           n_fail = 0;
   logic [127:0] rk [11];
   logic [127:0] ct_fips = 128'h3925841d02dc09fbdc118597196a0b32;
   logic [127:0] pt_fips = 128'h3243f6a8885a308d313198a2e0370734;
   logic [127:0] msg_b   = 128'h00112233445566778899aabbccddeeff;
   bit           both_seen = 1'b0;

   always @(negedge clock) if (done && ready) both_seen = 1'b1;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic add(input int unsigned off, input logic [7:0] ei, input logic [7:0] ek,
                      input logic en, input logic dn, input logic rd);
      vec[nv] = '{off, ei, ek, en, dn, rd};
      nv++;
   endtask

   function automatic logic [7:0] kb(input int r, input int b);
      logic [127:0] w;
      w = rk[r];
      return w[127-8*b -: 8];
   endfunction

   function automatic logic [7:0] cb(input int b);
      logic [127:0] w;
      w = ct_fips;
      return w[127-8*b -: 8];
   endfunction

   // Start at cycle T, walk the vector table through T+868.
   task automatic run_seq(input logic [127:0] msg, input logic [127:0] prev_pt,
                          input bit inject, input bit b2b);
      int idx;
      idx = 0;
      core_message = msg;
      ct_data = ct_fips;
      start = 1'b1;
      step();
      start = 1'b0;
      if (inject) ct_data = {$urandom, $urandom, $urandom, $urandom};
      for (int c = 1; c <= 868; c++) begin
         if (inject) begin
            start   = (c == 100);
            kw_en   = (c == 100);
            kw_addr = 8'd0;
            kw_data = 8'hff;
         end
         while (idx < nv && vec[idx].off == c) begin
            check($sformatf("core_in@T+%0d", c), core_in, vec[idx].exp_in);
            check($sformatf("core_key@T+%0d", c), core_key, vec[idx].exp_key);
            check($sformatf("core_enable@T+%0d", c), core_enable, vec[idx].exp_en);
            check($sformatf("done@T+%0d", c), done, vec[idx].exp_done);
            check($sformatf("ready@T+%0d", c), ready, vec[idx].exp_ready);
            idx++;
         end
         if (c == 866) check("pt_before_capture", pt, prev_pt);
         if (c == 867) check("pt_captured", pt, msg);
         if (c < 868) step();
      end
      if (b2b) begin
         ct_data = ct_fips;
         start = 1'b1;
         step();
         start = 1'b0;
         check("b2b_core_in", core_in, 8'h39);
         check("b2b_core_key", core_key, 8'hd0);
         check("b2b_enable", core_enable, 1'b1);
         for (int c = 2; c <= 900 && !done; c++) step();
         check("b2b_done_arrived", done, 1'b1);
         step();
      end
   endtask

   initial begin
      rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
      rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
      rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
      rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
      rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
      rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
      rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
      rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
      rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
      rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

      for (int i = 0; i < 16; i++) add(1 + i, cb(i), kb(10, i), 1'b1, 1'b0, 1'b0);
      add(17, 8'h32, 8'ha6, 1'b1, 1'b0, 1'b0);
      add(61, 8'h32, 8'ha6, 1'b1, 1'b0, 1'b0);
      for (int k = 1; k <= 10; k++) add(62 + (k - 1) * 81, 8'h32, kb(10 - k, 0), 1'b1, 1'b0, 1'b0);
      add(806, 8'h32, 8'h3c, 1'b1, 1'b0, 1'b0);
      add(807, 8'h32, 8'h3c, 1'b1, 1'b0, 1'b0);
      add(866, 8'h32, 8'h3c, 1'b1, 1'b0, 1'b0);
      add(867, 8'h32, 8'h3c, 1'b0, 1'b1, 1'b0);
      add(868, 8'h32, 8'h3c, 1'b0, 1'b0, 1'b1);

      #12;
      check("rst_ready", ready, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_enable", core_enable, 1'b0);
      check("rst_core_in", core_in, 8'h00);
      check("rst_core_key", core_key, 8'h00);
      check("rst_pt", pt, 128'h0);
      step();
      reset_n = 1'b1;
      step();

      for (int r = 0; r < 11; r++) begin
         for (int b = 0; b < 16; b++) begin
            kw_en   = 1'b1;
            kw_addr = 8'(16 * r + b);
            kw_data = kb(r, b);
            step();
         end
      end
      kw_en = 1'b0;
      step();

      run_seq(pt_fips, 128'h0, 1'b0, 1'b0);
      step();
      run_seq(msg_b, pt_fips, 1'b1, 1'b0);
      kw_en = 1'b0;
      start = 1'b0;
      step();

      // Abort mid-sequence; async clear then idle until a new start.
      core_message = pt_fips;
      ct_data = ct_fips;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int c = 1; c < 400; c++) step();
      check("mid_enable_high", core_enable, 1'b1);
      reset_n = 1'b0;
      #1;
      check("abort_ready", ready, 1'b1);
      check("abort_busy", busy, 1'b0);
      check("abort_done", done, 1'b0);
      check("abort_enable", core_enable, 1'b0);
      check("abort_core_in", core_in, 8'h00);
      check("abort_core_key", core_key, 8'h00);
      check("abort_pt", pt, 128'h0);
      step();
      step();
      step();
      reset_n = 1'b1;
      for (int c = 0; c < 5; c++) step();
      check("post_abort_idle", ready, 1'b1);
      check("post_abort_enable", core_enable, 1'b0);

      run_seq(pt_fips, 128'h0, 1'b0, 1'b1);
      check("done_and_ready_never_both", both_seen, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/aes_decrypt_sequencer.md
# aes_decrypt_sequencer

Control block for the byte-serial `decrypt` core. It holds the 11 AES-128 round keys in a local key store and accepts one 128-bit ciphertext per request. It then drives the core's `in`/`key`/`enable` pins with the ciphertext and the round keys, in reverse round order, in the exact cycle windows the core expects. When the core finishes, it captures `message` and signals completion with a done/ready handshake.

## Interface
Parameters:
- `FIRST_KEY_GAP`, 61: cycles from the start of burst 0 (ciphertext + round key 10) to the start of burst 1 (round key 9).
- `ROUND_PERIOD`, 81: cycles between the starts of bursts 1..10.
- `DONE_LAT`, 60: cycles from the last byte of burst 10 to the capture of `core_message`.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `kw_en` in 1: key-store write strobe.
- `kw_addr` in 8: key-store byte address, 16*round + byte, range 0..175.
- `kw_data` in 8: key-store write data.
- `start` in 1: request to decrypt `ct_data`; accepted when `start && ready`.
- `ct_data` in 128: ciphertext; byte 0 is `[127:120]`.
- `ready` out 1: idle, able to accept `start`.
- `busy` out 1: a sequence is in progress.
- `done` out 1: one-cycle pulse; `pt` is valid from this cycle.
- `pt` out 128: captured plaintext, held until the next capture.
- `core_in` out 8: drives `decrypt.in`.
- `core_key` out 8: drives `decrypt.key`.
- `core_enable` out 1: drives `decrypt.enable`.
- `core_message` in 128: from `decrypt.message`.

## Operation
- Key store: 176 x 8-bit registers, not reset.
  - Written only when `kw_en && !busy` and `kw_addr < 176`. All other writes are dropped.
  - Round r occupies addresses 16r..16r+15, with byte 0 streamed first.
- FSM states: IDLE, BURST0, GAP, BURST, DRAIN, DONE.
  - IDLE → BURST0 on `start && ready`. `ct_data` is latched into a shift register at acceptance.
  - BURST0 (16 cycles): `core_in` = ct byte i, `core_key` = rk10 byte i.
  - GAP: counts down to the next burst start. Enters BURST for rounds 9..0 in order.
  - BURST (16 cycles): `core_key` = rk[r] byte i. `core_in` holds its last value.
  - After the round-0 burst, → DRAIN for `DONE_LAT` cycles.
  - DRAIN → DONE: capture `core_message` into `pt`.
  - DONE → IDLE after one cycle.
- `core_key` and `core_in` hold their last driven value during GAP and DRAIN.
- `core_enable` is 1 from the first BURST0 cycle through the last DRAIN cycle, and 0 otherwise.
- `start` while busy is ignored; `ct_data` changes while busy have no effect.
- Counters:
  - byte counter: 4-bit, wraps 15→0 at burst end.
  - round counter: 4-bit, 10 down to 0.
  - gap counter: 8-bit.

## Timing
- Reset values:
  - `ready` = 1; `busy`, `done`, `core_enable` = 0.
  - `core_in`, `core_key`, `pt` = 0.
  - FSM in IDLE, all counters 0.
- All core-side outputs are registered.
- Burst boundaries, with `start` accepted at cycle T:
  - Byte 0 of burst 0 appears at T+1.
  - Burst k (k = 1..10) starts at T+1+`FIRST_KEY_GAP`+(k-1)*`ROUND_PERIOD`.
  - With the default parameters, the burst for round 0 occupies T+791..T+806.
- Completion:
  - `pt` is captured and `done` = 1 at T+807+`DONE_LAT` (T+867 with the defaults).
  - `ready` = 1 and `busy` = 0 from the following cycle.
- `ready` = !`busy` at all times. `done` and `ready` are never high in the same cycle.
- Reset asserted mid-sequence:
  - All outputs return to their reset values immediately (asynchronously).
  - `pt` is cleared; the key store is retained.
  - After release, the FSM stays in IDLE until a new `start`.
- `kw_en` in the same cycle as an accepted `start`: the write lands, because `busy` is still 0 in that cycle.

## Structure
- A shared package `aes_pkg` holds:
  - `NUM_ROUNDS` = 10, `BLOCK_BYTES` = 16, `KEY_STORE_BYTES` = 176.
  - The FSM state enum.
  - The default timing constants.
- Sub-module `aes_key_store`: 176-byte register file with one write port and one combinational read port. The read address is 16*round + byte.
- The top level is the FSM with its counters, the ciphertext shift register and the `pt` capture.

## Test plan
- FIPS-197 decryption:
  - Load rounds 0..10 for key 2b7e151628aed2a6abf7158809cf4f3c, then start with `ct_data` = 3925841d02dc09fbdc118597196a0b32.
  - At T+1..T+16, `core_in`/`core_key` = 39/d0, 25/14, ..., 32/a6.
  - At T+62, `core_key` = ac (round 9, byte 0).
  - With the real `decrypt` core attached, `pt` = 3243f6a8885a308d313198a2e0370734 with `done` at T+867.
- Window check: `core_key` at the start of each burst k (round 10−k) = ac, ea, 4e, 6d, d4, ef, 3d, f2, a0, 2b for k = 1..10. `core_enable` stays high for T+1..T+866.
- Busy protection:
  - Pulse `start` and write `kw_addr` = 0 with `kw_data` = ff at T+100.
  - No restart occurs; the key-store byte stays 2b.
  - The stream is unchanged and `done` still arrives at T+867.
- Reset mid-operation:
  - Drop `reset_n` at T+400 for 3 cycles.
  - All outputs return to reset values asynchronously.
  - A new `start` reproduces the FIPS-197 result without reloading keys.
- Back-to-back: assert `start` in the cycle after `done`. It is accepted, and its first byte appears one cycle later.
